stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
// Control sequencer for the 4-digit BCD stopwatch counter chain. Conditions two push-buttons
// (start_stop, lap_reset), runs the IDLE/RUN/PAUSE/LAP state machine and drives the counter:
// prescaled count-enable tick and clear. Selects live or lap-frozen digits for the display.
// Sits between the board buttons and the digit counter; the counter has no control logic of its own.
// PARAMETERS
// PRESCALE_MAX     14'd9999  prescaler terminal value; one count_en per PRESCALE_MAX+1 clocks (>=1)
// DEBOUNCE_CYCLES  16        lockout length after an accepted press, in clocks (>=1)
// PORTS
// clk           in   1   system clock; single clock domain
// reset         in   1   synchronous, active-high reset
// start_stop    in   1   raw start/stop button, asynchronous, active-high
// lap_reset     in   1   raw lap/reset button, asynchronous, active-high
// digits_in     in   16  live BCD digits from counter {10s,1s,0.1s,0.01s}, 4 bits each
// count_en      out  1   one-cycle advance strobe to the counter
// count_clr     out  1   one-cycle clear strobe to the counter
// display_out   out  16  digits to display: snapshot in LAP, else digits_in
// state_out     out  2   IDLE=00 RUN=01 PAUSE=10 LAP=11
// running       out  1   high in RUN or LAP
// BEHAVIOUR
// - Reset (sync, active-high): state IDLE, prescaler 0, snapshot 16'h0000, sync flops 0, lockout
//   counters 0. Outputs during/after reset: count_en=0, count_clr=0, state_out=00, running=0,
//   display_out=digits_in.
// - Per button: 3-flop synchroniser s[2:0]; edge = s[1] & ~s[2]. press = edge & (lockout==0).
//   Accepted press loads lockout with DEBOUNCE_CYCLES; lockout decrements to 0 each clock.
//   Edges during lockout are dropped. Input rising before edge N -> press high after edge N+1 ->
//   state changes at edge N+2. A button held across reset release yields one press after release.
// - FSM (ss = start_stop press, lr = lap_reset press; ss has priority, same-cycle lr is dropped):
//   IDLE : ss -> RUN; lr -> IDLE with count_clr pulse.
//   RUN  : ss -> PAUSE; lr -> LAP, snapshot <= digits_in at that edge.
//   LAP  : ss -> PAUSE (display goes live); lr -> RUN (display goes live).
//   PAUSE: ss -> RUN; lr -> IDLE with count_clr pulse.
//   count_clr is registered: high exactly one cycle, the cycle after the clearing transition edge.
// - Prescaler (width $clog2(PRESCALE_MAX+1)): increments each clock in RUN/LAP; at PRESCALE_MAX
//   wraps to 0. count_en = running & (prescaler==PRESCALE_MAX) (decoded from registers, one cycle
//   wide). PAUSE holds the prescaler value, so resume completes the partial period. Entering
//   IDLE clears the prescaler to 0.
// - If RUN->PAUSE coincides with prescaler==PRESCALE_MAX, count_en is still issued that cycle and
//   the prescaler wraps to 0.
// - Snapshot captures digits_in as sampled on the RUN->LAP edge. If count_en is high that cycle,
//   the pre-increment value is captured. Counting continues underneath LAP.
// - display_out is combinational: state==LAP ? snapshot : digits_in.
// - Reset mid-operation overrides everything: next cycle IDLE, no count_clr pulse issued
//   (the counter shares reset).
// TESTING (PRESCALE_MAX=4, DEBOUNCE_CYCLES=8)
// 1 reset, pulse start_stop 1 clk -> state 01 at 3rd edge; count_en every 5th clk, 1 clk wide.
// 2 RUN, stop with prescaler=2, wait 20 clks, start -> first count_en 2 clks after RUN re-entry.
// 3 RUN, digits_in=16'h0123 on lap edge -> state 11; display_out stays 0123 while digits_in
//   advances. Second lap_reset -> state 01 and display_out=digits_in.
// 4 PAUSE, lap_reset -> state 00; count_clr high exactly 1 clk; prescaler 0.
// 5 start_stop toggled 0-1-0-1 within 4 clks -> single press, state changes once; press at
//   lockout expiry +1 is accepted.
// 6 both buttons pressed same clk in RUN -> PAUSE, no snapshot. Reset asserted during LAP ->
//   state 00, count_en 0, display_out=digits_in next clk.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- control sequencer for the 4-digit BCD stopwatch counter chain.
//
// Conditions the two raw push-buttons, runs the stopwatch state machine, and
// produces the prescaled advance strobe and the clear strobe for the digit
// counter. It also selects live or lap-frozen digits for the display.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stopped at zero; prescaler held at 0
//   RUN   | counting; display shows live digits
//   PAUSE | counting suspended; prescaler keeps its partial period
//   LAP   | counting continues; display frozen on the lap snapshot
//
// Ports
//   clk          in   system clock, single domain
//   reset        in   synchronous active-high reset
//   start_stop   in   raw start/stop button (async, active-high)
//   lap_reset    in   raw lap/reset button (async, active-high)
//   digits_in    in   live BCD digits {10s,1s,0.1s,0.01s} from the counter
//   count_en     out  one-cycle advance strobe, once per PRESCALE_MAX+1 running clocks
//   count_clr    out  one-cycle clear strobe, the cycle after a clearing transition
//   display_out  out  snapshot while in LAP, otherwise digits_in
//   state_out    out  IDLE=00 RUN=01 PAUSE=10 LAP=11
//   running      out  high in RUN or LAP
module stopwatch_ctrl #(
  parameter int unsigned PRESCALE_MAX    = 9999,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap_reset,
  input  logic [15:0] digits_in,
  output logic        count_en,
  output logic        count_clr,
  output logic [15:0] display_out,
  output logic [1:0]  state_out,
  output logic        running
);

  localparam int unsigned PW = $clog2(PRESCALE_MAX + 1);
  localparam int unsigned LW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PS_MAX    = PW'(PRESCALE_MAX);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  logic [2:0]    ss_sync_q, ss_sync_d;
  logic [2:0]    lr_sync_q, lr_sync_d;
  logic [LW-1:0] ss_lock_q, ss_lock_d;
  logic [LW-1:0] lr_lock_q, lr_lock_d;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   snap_q, snap_d;
  logic          clr_q, clr_d;

  logic ss_edge, lr_edge;
  logic ss_press, lr_press;
  logic run_now;

  // Button conditioning: 3-flop synchroniser, rising-edge detect on the two
  // settled stages, then a lockout down-counter that swallows bounce edges.
  always_comb begin
    ss_sync_d = {ss_sync_q[1:0], start_stop};
    lr_sync_d = {lr_sync_q[1:0], lap_reset};

    ss_edge  = ss_sync_q[1] & ~ss_sync_q[2];
    lr_edge  = lr_sync_q[1] & ~lr_sync_q[2];
    ss_press = ss_edge & (ss_lock_q == '0);
    lr_press = lr_edge & (lr_lock_q == '0);

    ss_lock_d = ss_lock_q;
    if (ss_press)
      ss_lock_d = LOCK_LOAD;
    else if (ss_lock_q != '0)
      ss_lock_d = ss_lock_q - LW'(1);

    lr_lock_d = lr_lock_q;
    if (lr_press)
      lr_lock_d = LOCK_LOAD;
    else if (lr_lock_q != '0)
      lr_lock_d = lr_lock_q - LW'(1);
  end

  // State machine. start_stop wins a same-cycle collision; the lap_reset
  // press is simply ignored by the FSM in that case.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    clr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_press) begin
          state_d = ST_RUN;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_press) begin
          state_d = ST_PAUSE;
        end else if (lr_press) begin
          state_d = ST_LAP;
          snap_d  = digits_in;
        end
      end
      ST_LAP: begin
        if (ss_press)
          state_d = ST_PAUSE;
        else if (lr_press)
          state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_press) begin
          state_d = ST_RUN;
        end else if (lr_press) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler advances on every running clock, including the edge that
  // leaves RUN/LAP, so a stop on the terminal count still wraps to 0.
  // PAUSE holds the partial period; going to IDLE discards it.
  always_comb begin
    run_now = (state_q == ST_RUN) || (state_q == ST_LAP);
    presc_d = presc_q;
    if (run_now)
      presc_d = (presc_q == PS_MAX) ? '0 : presc_q + PW'(1);
    else if (state_d == ST_IDLE)
      presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_sync_q <= '0;
      lr_sync_q <= '0;
      ss_lock_q <= '0;
      lr_lock_q <= '0;
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      snap_q    <= '0;
      clr_q     <= 1'b0;
    end else begin
      ss_sync_q <= ss_sync_d;
      lr_sync_q <= lr_sync_d;
      ss_lock_q <= ss_lock_d;
      lr_lock_q <= lr_lock_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      snap_q    <= snap_d;
      clr_q     <= clr_d;
    end
  end

  assign running     = run_now;
  assign count_en    = run_now & (presc_q == PS_MAX);
  assign count_clr   = clr_q;
  assign state_out   = state_q;
  assign display_out = (state_q == ST_LAP) ? snap_q : digits_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with PRESCALE_MAX=4, DEBOUNCE_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap_reset = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        count_en;
  logic        count_clr;
  logic [15:0] display_out;
  logic [1:0]  state_out;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .PRESCALE_MAX   (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap_reset  (lap_reset),
    .digits_in  (digits_in),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .display_out(display_out),
    .state_out  (state_out),
    .running    (running)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-clock pulse; returns just after the edge on which the state updates.
  task automatic press_ss;
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    step(2);
  endtask

  task automatic press_lr;
    lap_reset = 1'b1;
    step(1);
    lap_reset = 1'b0;
    step(2);
  endtask

  initial begin
    // reset
    digits_in = 16'h1234;
    step(3);
    check_val("rst_state", state_out, 2'b00);
    check_val("rst_en", count_en, 1'b0);
    check_val("rst_clr", count_clr, 1'b0);
    check_val("rst_running", running, 1'b0);
    check_val("rst_display", display_out, 16'h1234);
    reset = 1'b0;
    step(1);
    check_val("idle_state", state_out, 2'b00);

    // 1: start, count_en every 5th clock
    press_ss;
    check_val("t1_state", state_out, 2'b01);
    check_val("t1_running", running, 1'b1);
    check_val("t1_en0", count_en, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      step(1);
      check_val($sformatf("t1_en%0d", i), count_en, (i % 5 == 4) ? 1'b1 : 1'b0);
    end

    // 2: stop (prescaler becomes 2), long pause, resume completes partial period
    press_ss;
    check_val("t2_pause", state_out, 2'b10);
    check_val("t2_running", running, 1'b0);
    step(20);
    check_val("t2_hold_state", state_out, 2'b10);
    check_val("t2_hold_en", count_en, 1'b0);
    press_ss;
    check_val("t2_resume", state_out, 2'b01);
    check_val("t2_en_r0", count_en, 1'b0);
    step(1);
    check_val("t2_en_r1", count_en, 1'b0);
    step(1);
    check_val("t2_en_r2", count_en, 1'b1);
    step(1);
    check_val("t2_en_r3", count_en, 1'b0);

    // 3: lap snapshot, counting continues, second lap_reset goes live
    digits_in = 16'h0123;
    press_lr;
    check_val("t3_lap", state_out, 2'b11);
    check_val("t3_running", running, 1'b1);
    check_val("t3_snap0", display_out, 16'h0123);
    digits_in = 16'h0124;
    step(1);
    check_val("t3_snap1", display_out, 16'h0123);
    check_val("t3_en_lap", count_en, 1'b1);
    digits_in = 16'h0125;
    step(1);
    check_val("t3_snap2", display_out, 16'h0123);
    step(8);
    digits_in = 16'h0456;
    press_lr;
    check_val("t3_run", state_out, 2'b01);
    check_val("t3_live", display_out, 16'h0456);

    // 4: PAUSE + lap_reset -> IDLE with one-cycle clear, prescaler zeroed
    press_ss;
    check_val("t4_pause", state_out, 2'b10);
    step(8);
    lap_reset = 1'b1;
    step(1);
    lap_reset = 1'b0;
    step(1);
    check_val("t4_clr_pre", count_clr, 1'b0);
    step(1);
    check_val("t4_idle", state_out, 2'b00);
    check_val("t4_clr", count_clr, 1'b1);
    step(1);
    check_val("t4_clr_post", count_clr, 1'b0);
    step(8);
    press_ss;
    check_val("t4_run", state_out, 2'b01);
    step(3);
    check_val("t4_en3", count_en, 1'b0);
    step(1);
    check_val("t4_en4", count_en, 1'b1);

    // 5: bouncing start_stop gives one press; press at lockout expiry accepted
    step(10);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    step(1);
    start_stop = 1'b1;
    step(1);
    check_val("t5_pause", state_out, 2'b10);
    start_stop = 1'b0;
    step(2);
    check_val("t5_bounce_dropped", state_out, 2'b10);
    step(4);
    start_stop = 1'b1;
    step(1);
    check_val("t5_wait1", state_out, 2'b10);
    step(1);
    check_val("t5_wait2", state_out, 2'b10);
    step(1);
    check_val("t5_expiry_press", state_out, 2'b01);
    start_stop = 1'b0;

    // 6: both buttons together -> PAUSE; reset during LAP
    step(10);
    digits_in = 16'h0789;
    start_stop = 1'b1;
    lap_reset = 1'b1;
    step(1);
    start_stop = 1'b0;
    lap_reset = 1'b0;
    step(2);
    check_val("t6_both_pause", state_out, 2'b10);
    check_val("t6_both_live", display_out, 16'h0789);
    step(10);
    press_ss;
    check_val("t6_run", state_out, 2'b01);
    step(10);
    press_lr;
    check_val("t6_lap", state_out, 2'b11);
    digits_in = 16'h0555;
    reset = 1'b1;
    step(1);
    check_val("t6_rst_state", state_out, 2'b00);
    check_val("t6_rst_en", count_en, 1'b0);
    check_val("t6_rst_running", running, 1'b0);
    check_val("t6_rst_clr", count_clr, 1'b0);
    check_val("t6_rst_display", display_out, 16'h0555);

    // button held across reset release -> exactly one press
    start_stop = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    check_val("held_r1", state_out, 2'b00);
    step(1);
    check_val("held_r2", state_out, 2'b00);
    step(1);
    check_val("held_r3", state_out, 2'b01);
    step(12);
    check_val("held_once", state_out, 2'b01);
    start_stop = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
